bcd_display_driver: RTL and testbench

Result-display stage sitting directly downstream of the calculator top level. It takes the registered result word `C` and `Carry`, converts `C` to BCD with a sequential shift-add-3 (double-dabble) engine, and holds the decimal digits. It drives two active-low seven-segment digits plus a carry indicator for the board display. Conversion is started by a one-cycle `start` pulse and reports completion with `busy`/`done`.

---
 rtl/bcd_display_driver_if.sv | 26 ++
 rtl/bcd_display_driver.sv | 130 +++++++++++++
 tb/tb_bcd_display_driver.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_driver_if.sv
// Bus between the calculator result stage and the BCD display driver:
// conversion request, result word, converted digits and seven-segment outputs.
interface bcd_display_driver_if #(
    parameter int Word_Length = 6,
    parameter int Num_Digits  = 2
);
    logic                      start;
    logic [Word_Length-1:0]    C;
    logic                      Carry;
    logic [4*Num_Digits-1:0]   BCD_Out;
    logic                      Carry_Out;
    logic [6:0]                Seg_Units;
    logic [6:0]                Seg_Tens;
    logic                      busy;
    logic                      done;

    modport master (
        output start, C, Carry,
        input  BCD_Out, Carry_Out, Seg_Units, Seg_Tens, busy, done
    );

    modport slave (
        input  start, C, Carry,
        output BCD_Out, Carry_Out, Seg_Units, Seg_Tens, busy, done
    );
endinterface

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter with registered digit
// outputs and active-low seven-segment decode for the units and tens digits.
module bcd_display_driver #(
    parameter int Word_Length = 6,
    parameter int Num_Digits  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_display_driver_if.slave  bus
);
    localparam int BcdW = 4 * Num_Digits;
    localparam int SrW  = BcdW + Word_Length;
    localparam int CntW = $clog2(Word_Length + 1);

    localparam logic [6:0] SegBlank = 7'b1111111;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

    state_e              state_q,     state_d;
    logic [SrW-1:0]      sr_q,        sr_d;
    logic [CntW-1:0]     cnt_q,       cnt_d;
    logic                carry_sh_q,  carry_sh_d;
    logic [BcdW-1:0]     bcd_out_q,   bcd_out_d;
    logic                carry_out_q, carry_out_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [6:0]          seg_units_q, seg_units_d;
    logic [6:0]          seg_tens_q,  seg_tens_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SegBlank;
        endcase
    endfunction

    // Scratch nibbles sit above the binary field; each one >= 5 is corrected
    // before the shift so it carries correctly into the next decimal place.
    function automatic logic [SrW-1:0] add3(input logic [SrW-1:0] v);
        logic [SrW-1:0] r;
        r = v;
        for (int i = 0; i < Num_Digits; i++) begin
            if (r[Word_Length + 4*i +: 4] >= 4'd5)
                r[Word_Length + 4*i +: 4] = r[Word_Length + 4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        carry_sh_d  = carry_sh_q;
        bcd_out_d   = bcd_out_q;
        carry_out_d = carry_out_q;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        seg_units_d = seg_decode(bcd_out_q[3:0]);
        seg_tens_d  = (bcd_out_q[7:4] == 4'd0) ? SegBlank : seg_decode(bcd_out_q[7:4]);

        case (state_q)
            ST_IDLE: begin
                busy_d = bus.start;
                if (bus.start) begin
                    sr_d       = {{BcdW{1'b0}}, bus.C};
                    carry_sh_d = bus.Carry;
                    cnt_d      = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = add3(sr_q) << 1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(Word_Length - 1))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                bcd_out_d   = sr_q[SrW-1 -: BcdW];
                carry_out_d = carry_sh_q;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            carry_sh_q  <= 1'b0;
            bcd_out_q   <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seg_units_q <= 7'b1000000;
            seg_tens_q  <= SegBlank;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            carry_sh_q  <= carry_sh_d;
            bcd_out_q   <= bcd_out_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            seg_units_q <= seg_units_d;
            seg_tens_q  <= seg_tens_d;
        end
    end

    assign bus.BCD_Out   = bcd_out_q;
    assign bus.Carry_Out = carry_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.Seg_Units = seg_units_q;
    assign bus.Seg_Tens  = seg_tens_q;
endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench: cycle-level behavioural model of the display driver
// compared every cycle, plus directed scenarios with literal expectations.
module tb_bcd_display_driver;
    localparam int WL = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    bcd_display_driver_if #(.Word_Length(WL), .Num_Digits(2)) bus ();

    bcd_display_driver #(.Word_Length(WL), .Num_Digits(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Behavioural model: age counts edges since the capture edge; the result
    // lands WL+1 edges after capture and the segments follow one edge later.
    int         m_age = 0;
    int         m_val = 0;
    bit         m_vcy = 1'b0;
    int         m_tens = 0;
    int         m_units = 0;
    bit         m_cy = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    logic [6:0] m_su = 7'b1000000;
    logic [6:0] m_st = 7'b1111111;

    always @(posedge clk) begin
        if (reset) begin
            m_age = 0; m_tens = 0; m_units = 0; m_cy = 0;
            m_busy = 0; m_done = 0;
            m_su = seg_of(0); m_st = 7'b1111111;
        end else begin
            m_su   = seg_of(m_units);
            m_st   = (m_tens == 0) ? 7'b1111111 : seg_of(m_tens);
            m_done = 1'b0;
            if (m_age == 0) begin
                m_busy = bus.start;
                if (bus.start) begin
                    m_val = int'(bus.C);
                    m_vcy = bus.Carry;
                    m_age = 1;
                end
            end else if (m_age == WL + 1) begin
                m_tens  = m_val / 10;
                m_units = m_val % 10;
                m_cy    = m_vcy;
                m_done  = 1'b1;
                m_busy  = 1'b1;
                m_age   = 0;
            end else begin
                m_age++;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_bcd",   int'(bus.BCD_Out),   m_tens * 16 + m_units);
            check("cyc_carry", int'(bus.Carry_Out), int'(m_cy));
            check("cyc_busy",  int'(bus.busy),      int'(m_busy));
            check("cyc_done",  int'(bus.done),      int'(m_done));
            check("cyc_segu",  int'(bus.Seg_Units), int'(m_su));
            check("cyc_segt",  int'(bus.Seg_Tens),  int'(m_st));
        end
    end

    // Returns just after E0 with start already dropped.
    task automatic start_conv(input int v, input bit cy);
        @(posedge clk); #1;
        bus.C = 6'(v); bus.Carry = cy; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic settle();
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        int lat;
        int busy_cnt, done_cnt;
        bus.start = 1'b0; bus.C = '0; bus.Carry = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_bcd",  int'(bus.BCD_Out),   0);
        check("rst_segu", int'(bus.Seg_Units), 'b1000000);
        check("rst_segt", int'(bus.Seg_Tens),  'b1111111);
        check("rst_busy", int'(bus.busy),      0);
        check("rst_done", int'(bus.done),      0);

        start_conv(0, 1'b0);
        wait_done(lat);
        check("c0_latency", lat, 8);
        settle();
        check("c0_bcd",  int'(bus.BCD_Out),   'h00);
        check("c0_segt", int'(bus.Seg_Tens),  'b1111111);
        check("c0_segu", int'(bus.Seg_Units), 'b1000000);

        start_conv(63, 1'b1);
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
        end
        check("c63_busy_cycles", busy_cnt, 8);
        check("c63_done_cycles", done_cnt, 1);
        check("c63_bcd",   int'(bus.BCD_Out),   'h63);
        check("c63_model", m_tens * 16 + m_units, 'h63);
        check("c63_carry", int'(bus.Carry_Out), 1);
        check("c63_segt",  int'(bus.Seg_Tens),  'b0000010);
        check("c63_segu",  int'(bus.Seg_Units), 'b0110000);

        for (int v = 0; v < 64; v++) begin
            start_conv(v, 1'($urandom_range(0, 1)));
            wait_done(lat);
            check("sweep_latency", lat, 8);
            check("sweep_bcd", int'(bus.BCD_Out), (v / 10) * 16 + v % 10);
            if (v == 9) begin
                settle();
                check("b9_segt", int'(bus.Seg_Tens),  'b1111111);
                check("b9_segu", int'(bus.Seg_Units), 'b0010000);
            end
            if (v == 10) begin
                settle();
                check("b10_bcd",  int'(bus.BCD_Out),   'h10);
                check("b10_segt", int'(bus.Seg_Tens),  'b1111001);
                check("b10_segu", int'(bus.Seg_Units), 'b1000000);
            end
        end

        start_conv(25, 1'b0);
        repeat (2) @(negedge clk);
        bus.C = 6'd40; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(lat);
        check("ign_bcd", int'(bus.BCD_Out), 'h25);
        bus.C = 6'd40; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(lat);
        check("b2b_latency", lat, 8);
        check("b2b_bcd", int'(bus.BCD_Out), 'h40);

        start_conv(12, 1'b0);
        bus.C = 6'd50;
        wait_done(lat);
        check("hold_bcd", int'(bus.BCD_Out), 'h12);

        start_conv(37, 1'b1);
        wait_done(lat);
        settle();
        start_conv(58, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            done_cnt += int'(bus.done);
        end
        check("rst_mid_done",  done_cnt, 0);
        check("rst_mid_bcd",   int'(bus.BCD_Out),   0);
        check("rst_mid_carry", int'(bus.Carry_Out), 0);
        check("rst_mid_busy",  int'(bus.busy),      0);
        check("rst_mid_segu",  int'(bus.Seg_Units), 'b1000000);
        check("rst_mid_segt",  int'(bus.Seg_Tens),  'b1111111);
        start_conv(58, 1'b0);
        wait_done(lat);
        check("post_rst_bcd", int'(bus.BCD_Out), 'h58);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            bus.start = ($urandom_range(0, 3) == 0);
            bus.C     = 6'($urandom_range(0, 63));
            bus.Carry = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 79) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0; bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
